// File: rtl/mandelbrot_chunk_sched_if.sv
// mandelbrot_chunk_sched_if: chunk handshake between the job sequencer and the engine
interface mandelbrot_chunk_sched_if #(
  parameter int AW = 64,
  parameter int LW = 32
);
  logic          start;
  logic [AW-1:0] addr_offset;
  logic [LW-1:0] length;
  logic          done;
  modport master (output start, addr_offset, length, input done);
  modport slave  (input start, addr_offset, length, output done);
endinterface

// File: rtl/mandelbrot_chunk_sched.sv
// mandelbrot_chunk_sched: splits one host job into aligned chunks and issues them to the engine one at a time
module mandelbrot_chunk_sched #(
  parameter int C_ADDR_WIDTH      = 64,
  parameter int C_LENGTH_WIDTH    = 32,
  parameter int C_MAX_CHUNK_BYTES = 4096,
  parameter int C_ALIGN_BYTES     = 64,
  parameter int C_TIMEOUT_CYCLES  = 65536
) (
  input  logic                      ap_clk,
  input  logic                      areset,
  input  logic                      ap_start,
  output logic                      ap_idle,
  output logic                      ap_done,
  input  logic [C_ADDR_WIDTH-1:0]   ctrl_addr_offset,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_length,
  input  logic [C_LENGTH_WIDTH-1:0] ctrl_chunk_bytes,
  mandelbrot_chunk_sched_if.master  eng,
  output logic                      status_error,
  output logic [15:0]               status_chunks
);
  localparam int CW = $clog2(C_TIMEOUT_CYCLES);
  localparam logic [C_LENGTH_WIDTH-1:0] MAXC  = C_LENGTH_WIDTH'(C_MAX_CHUNK_BYTES);
  localparam logic [C_LENGTH_WIDTH-1:0] ALIGN = C_LENGTH_WIDTH'(C_ALIGN_BYTES);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DONE} state_t;
  state_t                    state;
  logic                      ap_start_q, start_edge;
  logic [C_ADDR_WIDTH-1:0]   addr, next_addr;
  logic [C_LENGTH_WIDTH-1:0] rem, chunk, c_req, c_eff, new_rem, launch_len, next_len;
  logic [CW-1:0]             cnt;
  always_comb begin
    start_edge = ap_start & ~ap_start_q;
    c_req      = (ctrl_chunk_bytes < MAXC ? ctrl_chunk_bytes : MAXC) & ~(ALIGN - 1'b1);
    c_eff      = c_req == '0 ? ALIGN : c_req;
    launch_len = rem < chunk ? rem : chunk;
    new_rem    = rem - eng.length;
    next_len   = new_rem < chunk ? new_rem : chunk;
    next_addr  = addr + C_ADDR_WIDTH'(eng.length);
  end
  always_ff @(posedge ap_clk) begin
    if (areset) begin
      state           <= IDLE;
      ap_start_q      <= 1'b0;
      ap_idle         <= 1'b1;
      ap_done         <= 1'b0;
      eng.start       <= 1'b0;
      eng.addr_offset <= '0;
      eng.length      <= '0;
      status_error    <= 1'b0;
      status_chunks   <= '0;
      addr            <= '0;
      rem             <= '0;
      chunk           <= '0;
      cnt             <= '0;
    end else begin
      ap_start_q <= ap_start;
      eng.start  <= 1'b0;
      ap_done    <= 1'b0;
      case (state)
        IDLE: begin
          ap_idle <= ~start_edge;
          if (start_edge) begin
            addr          <= ctrl_addr_offset;
            rem           <= ctrl_length;
            chunk         <= c_eff;
            status_chunks <= '0;
            status_error  <= 1'b0;
            state         <= ctrl_length == '0 ? DONE : LAUNCH;
          end
        end
        LAUNCH: begin
          eng.start       <= 1'b1;
          eng.addr_offset <= addr;
          eng.length      <= launch_len;
          cnt             <= '0;
          state           <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          if (eng.done) begin
            addr          <= next_addr;
            rem           <= new_rem;
            status_chunks <= status_chunks + 16'(status_chunks != 16'hFFFF);
            if (new_rem == '0) state <= DONE;
            else begin
              // reissue directly so the next chunk starts the cycle after eng_done
              eng.start       <= 1'b1;
              eng.addr_offset <= next_addr;
              eng.length      <= next_len;
              cnt             <= '0;
            end
          end else if (cnt == CW'(C_TIMEOUT_CYCLES - 1)) begin
            status_error <= 1'b1;
            state        <= DONE;
          end
        end
        DONE: begin
          ap_done <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mandelbrot_chunk_sched.sv
// tb_mandelbrot_chunk_sched: directed checks of chunking, latency, timeout, ignore and reset behaviour
module tb_mandelbrot_chunk_sched;
  localparam int AW = 64;
  localparam int LW = 32;
  logic          ap_clk = 0, areset = 1, ap_start = 0;
  logic          ap_idle, ap_done, status_error;
  logic [15:0]   status_chunks;
  logic [AW-1:0] ctrl_addr_offset = '0;
  logic [LW-1:0] ctrl_length = '0, ctrl_chunk_bytes = '0;
  logic          resp_done = 0, stray_done = 0;
  bit            resp_en = 1;
  int            cyc = 0, n_starts = 0, n_done = 0, done_cyc = 0, cd = 0;
  int            n_chk = 0, n_fail = 0;
  logic [AW-1:0] s_addr [64];
  logic [LW-1:0] s_len [64];
  int            s_cyc [64];
  always #5 ap_clk = ~ap_clk;
  mandelbrot_chunk_sched_if #(.AW(AW), .LW(LW)) eng ();
  assign eng.done = resp_done | stray_done;
  mandelbrot_chunk_sched #(.C_TIMEOUT_CYCLES(16)) dut (
    .ap_clk(ap_clk), .areset(areset), .ap_start(ap_start), .ap_idle(ap_idle), .ap_done(ap_done),
    .ctrl_addr_offset(ctrl_addr_offset), .ctrl_length(ctrl_length), .ctrl_chunk_bytes(ctrl_chunk_bytes),
    .eng(eng), .status_error(status_error), .status_chunks(status_chunks)
  );
  always @(posedge ap_clk) cyc <= cyc + 1;
  // monitor and engine model: eng_done pulses 5 cycles after each eng_start
  always @(negedge ap_clk) begin
    if (eng.start && n_starts < 64) begin
      s_addr[n_starts] = eng.addr_offset;
      s_len[n_starts]  = eng.length;
      s_cyc[n_starts]  = cyc;
      n_starts++;
    end
    if (ap_done) begin
      n_done++;
      done_cyc = cyc;
    end
    resp_done = 0;
    if (eng.start && resp_en) cd = 5;
    else if (cd > 0) begin
      cd--;
      resp_done = cd == 0;
    end
  end
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic start_job(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [LW-1:0] c, output int t);
    @(negedge ap_clk);
    ctrl_addr_offset = a;
    ctrl_length      = l;
    ctrl_chunk_bytes = c;
    ap_start         = 1;
    t                = cyc;
    @(negedge ap_clk);
    ap_start = 0;
  endtask
  task automatic wait_done(input int prev);
    for (int k = 0; k < 500 && n_done == prev; k++) @(negedge ap_clk);
    check("done_wait", 64'(n_done != prev), 1);
    repeat (3) @(negedge ap_clk);
  endtask
  task automatic check_seq(input string tag, input int s0, input logic [AW-1:0] base, input int len, input int c);
    int rem = len, i = 0;
    logic [AW-1:0] a = base;
    while (rem > 0) begin
      int l = rem < c ? rem : c;
      check($sformatf("%s_addr%0d", tag, i), s_addr[s0 + i], a);
      check($sformatf("%s_len%0d", tag, i), 64'(s_len[s0 + i]), 64'(l));
      a += AW'(l);
      rem -= l;
      i++;
    end
    check($sformatf("%s_count", tag), 64'(n_starts - s0), 64'(i));
  endtask
  task automatic check_reset_vals(input string tag);
    check({tag, "_idle"}, 64'(ap_idle), 1);
    check({tag, "_done"}, 64'(ap_done), 0);
    check({tag, "_estart"}, 64'(eng.start), 0);
    check({tag, "_eaddr"}, eng.addr_offset, 0);
    check({tag, "_elen"}, 64'(eng.length), 0);
    check({tag, "_err"}, 64'(status_error), 0);
    check({tag, "_chunks"}, 64'(status_chunks), 0);
  endtask
  initial begin
    int t, s0, d0;
    repeat (3) @(negedge ap_clk);
    check_reset_vals("rst");
    areset = 0;
    s0 = n_starts; d0 = n_done;
    start_job(64'h1000, 10000, 4096, t);
    wait_done(d0);
    check("a_addr0", s_addr[s0], 64'h1000);
    check("a_len0", 64'(s_len[s0]), 4096);
    check("a_addr1", s_addr[s0 + 1], 64'h2000);
    check("a_len1", 64'(s_len[s0 + 1]), 4096);
    check("a_addr2", s_addr[s0 + 2], 64'h3000);
    check("a_len2", 64'(s_len[s0 + 2]), 1808);
    check("a_count", 64'(n_starts - s0), 3);
    check("a_first_lat", 64'(s_cyc[s0] - t), 2);
    check("a_gap", 64'(s_cyc[s0 + 1] - s_cyc[s0]), 6);
    check("a_done_lat", 64'(done_cyc - s_cyc[s0 + 2]), 7);
    check("a_ndone", 64'(n_done - d0), 1);
    check("a_chunks", 64'(status_chunks), 3);
    check("a_err", 64'(status_error), 0);
    check("a_idle", 64'(ap_idle), 1);
    s0 = n_starts; d0 = n_done;
    @(negedge ap_clk);
    ctrl_length = 0;
    ap_start    = 1;
    @(negedge ap_clk);
    ap_start = 0;
    check("z_idle1", 64'(ap_idle), 0);
    check("z_done1", 64'(ap_done), 0);
    @(negedge ap_clk);
    check("z_idle2", 64'(ap_idle), 0);
    check("z_done2", 64'(ap_done), 1);
    @(negedge ap_clk);
    check("z_idle3", 64'(ap_idle), 1);
    check("z_done3", 64'(ap_done), 0);
    repeat (3) @(negedge ap_clk);
    check("z_nostart", 64'(n_starts - s0), 0);
    check("z_chunks", 64'(status_chunks), 0);
    check("z_ndone", 64'(n_done - d0), 1);
    s0 = n_starts; d0 = n_done;
    start_job(64'h2000, 200, 100, t);
    wait_done(d0);
    check_seq("b", s0, 64'h2000, 200, 64);
    check("b_chunks", 64'(status_chunks), 4);
    s0 = n_starts; d0 = n_done;
    start_job(64'h40, 128, 0, t);
    wait_done(d0);
    check_seq("c0", s0, 64'h40, 128, 64);
    check("c0_chunks", 64'(status_chunks), 2);
    resp_en = 0;
    s0 = n_starts; d0 = n_done;
    start_job(64'h3000, 256, 64, t);
    wait_done(d0);
    check("to_count", 64'(n_starts - s0), 1);
    check("to_addr", s_addr[s0], 64'h3000);
    check("to_done_lat", 64'(done_cyc - s_cyc[s0]), 17);
    check("to_err", 64'(status_error), 1);
    check("to_chunks", 64'(status_chunks), 0);
    resp_en = 1;
    s0 = n_starts; d0 = n_done;
    start_job(64'h8000, 192, 64, t);
    repeat (3) @(negedge ap_clk);
    ctrl_addr_offset = 64'hDEAD0000;
    ctrl_length      = 4096;
    ap_start         = 1;
    @(negedge ap_clk);
    ap_start = 0;
    wait_done(d0);
    stray_done = 1;
    @(negedge ap_clk);
    stray_done = 0;
    repeat (3) @(negedge ap_clk);
    check_seq("ig", s0, 64'h8000, 192, 64);
    check("ig_chunks", 64'(status_chunks), 3);
    check("ig_err", 64'(status_error), 0);
    check("ig_ndone", 64'(n_done - d0), 1);
    s0 = n_starts; d0 = n_done;
    start_job(64'h5000, 256, 64, t);
    repeat (9) @(negedge ap_clk);
    areset = 1;
    @(negedge ap_clk);
    check_reset_vals("mid");
    areset = 0;
    repeat (6) @(negedge ap_clk);
    check("mid_starts", 64'(n_starts - s0), 2);
    check("mid_chunks", 64'(status_chunks), 0);
    check("mid_ndone", 64'(n_done - d0), 0);
    check("mid_idle", 64'(ap_idle), 1);
    s0 = n_starts; d0 = n_done;
    start_job(64'h6000, 128, 64, t);
    wait_done(d0);
    check_seq("post", s0, 64'h6000, 128, 64);
    check("post_chunks", 64'(status_chunks), 2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
